// File: rtl/song_sequencer.sv
// Song playback sequencer: walks one song in the note ROM entry by entry, holds
// each note for its duration in beats and reports the end of the song.
module song_sequencer #(
    parameter int SONG_W  = 2,
    parameter int NOTE_W  = 5,
    parameter int PITCH_W = 6,
    parameter int DUR_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      play,
    input  logic [1:0]                play_state,
    input  logic [SONG_W-1:0]         song,
    input  logic                      new_song,
    input  logic                      beat,
    output logic [SONG_W+NOTE_W-1:0]  rom_addr,
    input  logic [PITCH_W+DUR_W-1:0]  rom_data,
    output logic [PITCH_W-1:0]        note_out,
    output logic                      new_note,
    output logic                      song_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_PLAY    = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0]         PS_DOUBLE  = 2'b01;
    localparam logic [1:0]         PS_REVERSE = 2'b10;
    localparam logic [NOTE_W-1:0]  IDX_ZERO   = {NOTE_W{1'b0}};
    localparam logic [NOTE_W-1:0]  IDX_ONE    = {{(NOTE_W-1){1'b0}}, 1'b1};
    localparam logic [NOTE_W-1:0]  IDX_MAX    = {NOTE_W{1'b1}};
    localparam logic [DUR_W-1:0]   DUR_ZERO   = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0]   DUR_ONE    = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0]   DUR_TWO    = {{(DUR_W-2){1'b0}}, 2'b10};
    localparam logic [PITCH_W-1:0] PITCH_ZERO = {PITCH_W{1'b0}};
    localparam logic [SONG_W-1:0]  SONG_ZERO  = {SONG_W{1'b0}};

    state_t              state_r, state_s;
    logic [SONG_W-1:0]   song_r, song_s;
    logic [NOTE_W-1:0]   idx_r, idx_s;
    logic [DUR_W-1:0]    dur_cnt_r, dur_cnt_s;
    logic [PITCH_W-1:0]  note_r, note_s;
    logic                new_note_r, new_note_s;
    logic                song_done_r, song_done_s;
    logic [SONG_W+NOTE_W-1:0] rom_addr_r;

    logic [PITCH_W-1:0]  rom_pitch_s;
    logic [DUR_W-1:0]    rom_dur_s;
    logic [DUR_W-1:0]    dur_dec_s;
    logic                reverse_s;
    logic                at_end_s;

    // Saturating beat decrement; double time removes up to two beats per tick.
    function automatic logic [DUR_W-1:0] beat_decrement(input logic [DUR_W-1:0] cnt,
                                                       input logic            dbl);
        logic [DUR_W-1:0] res;
        if (dbl && (cnt >= DUR_TWO)) begin
            res = cnt - DUR_TWO;
        end else if (cnt != DUR_ZERO) begin
            res = cnt - DUR_ONE;
        end else begin
            res = DUR_ZERO;
        end
        return res;
    endfunction

    assign rom_pitch_s = rom_data[PITCH_W+DUR_W-1:DUR_W];
    assign rom_dur_s   = rom_data[DUR_W-1:0];
    assign dur_dec_s   = beat_decrement(dur_cnt_r, play_state == PS_DOUBLE);
    assign reverse_s   = (play_state == PS_REVERSE);
    assign at_end_s    = reverse_s ? (idx_r == IDX_ZERO) : (idx_r == IDX_MAX);

    // Next-state, index, duration counter and output-pulse decode.
    always_comb begin
        state_s     = state_r;
        song_s      = song_r;
        idx_s       = idx_r;
        dur_cnt_s   = dur_cnt_r;
        note_s      = note_r;
        new_note_s  = 1'b0;
        song_done_s = 1'b0;
        if (new_song) begin
            song_s    = song;
            idx_s     = reverse_s ? IDX_MAX : IDX_ZERO;
            dur_cnt_s = DUR_ZERO;
            note_s    = PITCH_ZERO;
            state_s   = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = play ? ST_FETCH : ST_IDLE;
                end
                ST_FETCH: begin
                    state_s = ST_LOAD;
                end
                ST_LOAD: begin
                    // A zero duration marks the end of the song, not a note.
                    if (rom_dur_s == DUR_ZERO) begin
                        note_s      = PITCH_ZERO;
                        song_done_s = 1'b1;
                        state_s     = ST_DONE;
                    end else begin
                        note_s     = rom_pitch_s;
                        dur_cnt_s  = rom_dur_s;
                        new_note_s = 1'b1;
                        state_s    = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (beat && play) begin
                        dur_cnt_s = dur_dec_s;
                        state_s   = (dur_dec_s == DUR_ZERO) ? ST_ADVANCE : ST_PLAY;
                    end else begin
                        dur_cnt_s = dur_cnt_r;
                        state_s   = ST_PLAY;
                    end
                end
                ST_ADVANCE: begin
                    if (at_end_s) begin
                        note_s      = PITCH_ZERO;
                        song_done_s = 1'b1;
                        state_s     = ST_DONE;
                    end else begin
                        idx_s   = reverse_s ? (idx_r - IDX_ONE) : (idx_r + IDX_ONE);
                        state_s = ST_FETCH;
                    end
                end
                ST_DONE: begin
                    note_s  = PITCH_ZERO;
                    state_s = ST_DONE;
                end
                default: begin
                    note_s  = PITCH_ZERO;
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; rom_addr tracks the next {song, idx}.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            song_r      <= SONG_ZERO;
            idx_r       <= IDX_ZERO;
            dur_cnt_r   <= DUR_ZERO;
            note_r      <= PITCH_ZERO;
            new_note_r  <= 1'b0;
            song_done_r <= 1'b0;
            rom_addr_r  <= {SONG_ZERO, IDX_ZERO};
        end else begin
            state_r     <= state_s;
            song_r      <= song_s;
            idx_r       <= idx_s;
            dur_cnt_r   <= dur_cnt_s;
            note_r      <= note_s;
            new_note_r  <= new_note_s;
            song_done_r <= song_done_s;
            rom_addr_r  <= {song_s, idx_s};
        end
    end

    assign rom_addr  = rom_addr_r;
    assign note_out  = note_r;
    assign new_note  = new_note_r;
    assign song_done = song_done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: synchronous ROM model, randomized play controls and a
// phase-level reference model of song playback compared every cycle.
module tb_song_sequencer;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 12;

    localparam int PH_WAIT  = 0;  // waiting for play
    localparam int PH_LOAD  = 1;  // entry on its way from the ROM
    localparam int PH_SOUND = 2;  // note sounding, counting beats
    localparam int PH_STEP  = 3;  // choosing the next entry
    localparam int PH_END   = 4;  // song finished

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, play, new_song, beat;
    logic [1:0]        play_state, song;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [5:0]        note_out;
    logic              new_note, song_done;

    logic [DATA_W-1:0] rom_mem [0:127];

    song_sequencer dut (
        .clk(clk), .rst(rst), .play(play), .play_state(play_state), .song(song),
        .new_song(new_song), .beat(beat), .rom_addr(rom_addr), .rom_data(rom_data),
        .note_out(note_out), .new_note(new_note), .song_done(song_done)
    );

    // One-cycle-latency song ROM.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int n_cmp = 0;
    int n_err = 0;

    int         m_phase, m_wait, m_beats;
    logic [1:0] m_song;
    logic [4:0] m_idx;
    logic [5:0] m_note;
    logic       m_new, m_done;

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_step();
        logic [DATA_W-1:0] entry;
        logic              rev;
        m_new  = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_phase = PH_WAIT; m_wait = 0; m_beats = 0;
            m_song = 2'd0; m_idx = 5'd0; m_note = 6'd0;
        end else if (new_song) begin
            m_song  = song;
            m_idx   = (play_state == 2'b10) ? 5'd31 : 5'd0;
            m_note  = 6'd0; m_beats = 0; m_phase = PH_WAIT;
        end else begin
            case (m_phase)
                PH_WAIT: if (play) begin m_phase = PH_LOAD; m_wait = 1; end
                PH_LOAD: begin
                    if (m_wait > 0) m_wait--;
                    else begin
                        entry = rom_mem[{m_song, m_idx}];
                        if (entry[5:0] == 6'd0) begin
                            m_phase = PH_END; m_note = 6'd0; m_done = 1'b1;
                        end else begin
                            m_note = entry[11:6]; m_beats = int'(entry[5:0]);
                            m_new = 1'b1; m_phase = PH_SOUND;
                        end
                    end
                end
                PH_SOUND: begin
                    if (beat && play) begin
                        if (play_state == 2'b01 && m_beats >= 2) m_beats -= 2;
                        else m_beats -= 1;
                        if (m_beats == 0) m_phase = PH_STEP;
                    end
                end
                PH_STEP: begin
                    rev = (play_state == 2'b10);
                    if (rev ? (m_idx == 5'd0) : (m_idx == 5'd31)) begin
                        m_phase = PH_END; m_note = 6'd0; m_done = 1'b1;
                    end else begin
                        m_idx = rev ? m_idx - 5'd1 : m_idx + 5'd1;
                        m_phase = PH_LOAD; m_wait = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic run_cycle();
        model_step();
        @(posedge clk);
        #1;
        check_value("note_out", {10'd0, note_out}, {10'd0, m_note});
        check_value("new_note", {15'd0, new_note}, {15'd0, m_new});
        check_value("song_done", {15'd0, song_done}, {15'd0, m_done});
        check_value("rom_addr", {9'd0, rom_addr}, {9'd0, m_song, m_idx});
    endtask

    task automatic fill_rom(input int zero_pct, input int max_dur);
        for (int i = 0; i < 128; i++) begin
            rom_mem[i][11:6] = 6'($urandom_range(63, 0));
            if ($urandom_range(99, 0) < zero_pct) rom_mem[i][5:0] = 6'd0;
            else rom_mem[i][5:0] = 6'($urandom_range(max_dur, 1));
        end
    endtask

    initial begin
        rst = 1'b1; play = 1'b0; new_song = 1'b0; beat = 1'b0;
        play_state = 2'b00; song = 2'd0;
        fill_rom(0, 4);
        rom_mem[32] = {6'd5, 6'd3};
        rom_mem[33] = {6'd7, 6'd2};

        // Reset, select song 1, then play: first note after three cycles.
        run_cycle();
        check_value("rst_addr", {9'd0, rom_addr}, 16'd0);
        check_value("rst_note", {10'd0, note_out}, 16'd0);
        rst = 1'b0; new_song = 1'b1; song = 2'd1;
        run_cycle();
        new_song = 1'b0; play = 1'b1;
        run_cycle();
        check_value("t1_addr", {9'd0, rom_addr}, 16'd32);
        run_cycle();
        run_cycle();
        check_value("t1_note", {10'd0, note_out}, 16'd5);
        check_value("t1_new", {15'd0, new_note}, 16'd1);
        beat = 1'b1;
        repeat (3) run_cycle();
        beat = 1'b0;
        run_cycle();
        run_cycle();
        check_value("t1_next_addr", {9'd0, rom_addr}, 16'd33);
        repeat (4) run_cycle();
        check_value("t1_next_note", {10'd0, note_out}, 16'd7);

        // Reverse start on song 2 begins at the last entry.
        play_state = 2'b10; new_song = 1'b1; song = 2'd2;
        run_cycle();
        new_song = 1'b0;
        check_value("t3_addr", {9'd0, rom_addr}, 16'd95);
        check_value("t3_note", {10'd0, note_out}, 16'd0);

        // Randomized sessions with mode changes, pauses, restarts and resets.
        for (int seg = 0; seg < 30; seg++) begin
            fill_rom((seg % 3) * 7, 1 + (seg % 5));
            rst = 1'b1;
            run_cycle();
            rst = 1'b0;
            play_state = 2'($urandom_range(3, 0));
            song = 2'($urandom_range(3, 0));
            new_song = 1'b1;
            run_cycle();
            new_song = 1'b0;
            for (int c = 0; c < 600; c++) begin
                play = ($urandom_range(9, 0) != 0);
                beat = ($urandom_range(1, 0) == 0);
                if ($urandom_range(19, 0) == 0) play_state = 2'($urandom_range(3, 0));
                song = 2'($urandom_range(3, 0));
                new_song = ($urandom_range(399, 0) == 0);
                rst = ($urandom_range(699, 0) == 0);
                run_cycle();
            end
            rst = 1'b0; new_song = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
